// File: rtl/p09_segment_bar_painter_pkg.sv
// Shared constants for the segment bar painter: colours, line geometry and
// the frame-start decode.
package p09_segment_bar_painter_pkg;

  localparam int HPOS_W = 10;
  localparam int VPOS_W = 9;

  // Colours are packed BBGGRR.
  localparam logic [5:0] COLOR_BAR_DEFAULT   = 6'b111111;
  localparam logic [5:0] COLOR_FLASH_DEFAULT = 6'b000011;

  localparam logic [HPOS_W-1:0] H_LAST_DEFAULT = 10'd799;

  function automatic logic frame_start(input logic [HPOS_W-1:0] h,
                                       input logic [VPOS_W-1:0] v);
    return (h == '0) && (v == '0);
  endfunction

endpackage

// File: rtl/p09_segment_bar_painter_counter.sv
// Horizontal span tracker: walks seg_x/segment across the bar and clips
// at the end of the line.
module p09_segment_counter
  import p09_segment_bar_painter_pkg::*;
#(
  parameter int                SEG_WIDTH = 8,
  parameter logic [HPOS_W-1:0] H_LAST    = H_LAST_DEFAULT
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic [HPOS_W-1:0] hpos,
  input  logic [HPOS_W-1:0] x_lat,
  input  logic [3:0]        nseg_lat,
  output logic              in_x,
  output logic [3:0]        segment
);

  localparam logic [3:0] SEG_LAST = 4'(SEG_WIDTH - 1);

  logic [3:0] seg_x;
  logic       start;
  logic       seg_end;
  logic       bar_end;
  logic       clip;

  assign start   = (hpos == x_lat) && (nseg_lat != 4'd0);
  assign seg_end = (seg_x == SEG_LAST);
  assign bar_end = seg_end && (segment == (nseg_lat - 4'd1));
  assign clip    = (hpos == H_LAST);

  // Start outranks both the natural end and the line clip.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      in_x    <= 1'b0;
      seg_x   <= 4'd0;
      segment <= 4'd0;
    end else if (start) begin
      in_x    <= 1'b1;
      seg_x   <= 4'd0;
      segment <= 4'd0;
    end else if (clip || (in_x && bar_end)) begin
      in_x    <= 1'b0;
      seg_x   <= 4'd0;
      segment <= 4'd0;
    end else if (in_x) begin
      if (seg_end) begin
        seg_x   <= 4'd0;
        segment <= segment + 4'd1;
      end else begin
        seg_x <= seg_x + 4'd1;
      end
    end
  end

endmodule

// File: rtl/p09_segment_bar_painter.sv
// Segmented horizontal bar overlay with frame-synchronous position/length
// latching and a frame-counted colour flash.
module p09_segment_bar_painter
  import p09_segment_bar_painter_pkg::*;
#(
  parameter logic [5:0]        BAR_COLOR    = COLOR_BAR_DEFAULT,
  parameter logic [5:0]        FLASH_COLOR  = COLOR_FLASH_DEFAULT,
  parameter int                SEG_WIDTH    = 8,
  parameter int                MAX_SEGMENTS = 8,
  parameter logic [8:0]        BAR_HEIGHT   = 9'd8,
  parameter logic [8:0]        BAR_Y        = 9'd456,
  parameter logic [HPOS_W-1:0] H_LAST       = H_LAST_DEFAULT,
  parameter logic [3:0]        FLASH_FRAMES = 4'd8
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic [HPOS_W-1:0] hpos,
  input  logic [VPOS_W-1:0] vpos,
  input  logic [HPOS_W-1:0] x,
  input  logic [3:0]        num_seg,
  input  logic              flash,
  output logic              in_bar,
  output logic [5:0]        color,
  output logic [3:0]        segment,
  output logic              flashing
);

  localparam logic [3:0] NSEG_MAX = 4'(MAX_SEGMENTS);
  localparam logic [8:0] Y_END    = BAR_Y + BAR_HEIGHT;

  logic [HPOS_W-1:0] x_lat;
  logic [3:0]        nseg_lat;
  logic              in_x;
  logic              in_y;
  logic [3:0]        seg_cnt;
  logic [3:0]        flash_cnt;
  logic              fstart;

  assign fstart = frame_start(hpos, vpos);

  // Geometry only changes at frame start so a frame never tears.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      x_lat    <= '0;
      nseg_lat <= 4'd0;
    end else if (fstart) begin
      x_lat    <= x;
      nseg_lat <= (num_seg > NSEG_MAX) ? NSEG_MAX : num_seg;
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      in_y <= 1'b0;
    end else if (vpos == BAR_Y) begin
      in_y <= 1'b1;
    end else if (vpos == Y_END) begin
      in_y <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      flash_cnt <= 4'd0;
    end else if (flash) begin
      flash_cnt <= FLASH_FRAMES;
    end else if (fstart && (flash_cnt != 4'd0)) begin
      flash_cnt <= flash_cnt - 4'd1;
    end
  end

  p09_segment_counter #(
    .SEG_WIDTH (SEG_WIDTH),
    .H_LAST    (H_LAST)
  ) u_seg_cnt (
    .clk      (clk),
    .nRst     (nRst),
    .hpos     (hpos),
    .x_lat    (x_lat),
    .nseg_lat (nseg_lat),
    .in_x     (in_x),
    .segment  (seg_cnt)
  );

  assign in_bar   = in_x & in_y;
  assign segment  = in_bar ? seg_cnt : 4'd0;
  assign flashing = (flash_cnt != 4'd0);
  assign color    = flashing ? FLASH_COLOR : BAR_COLOR;

endmodule
